isp_byte_fifo_ctrl: RTL

- Synchronous FWFT byte-FIFO controller that sequences the 64x8 single-clock two-port SRAM core (instantiated alongside it; all RAM ports are driven from this block) into a ready/valid stream buffer.
- Sits between the MSS-side byte source (APB/UART shim) and the ISP bitstream consumer.
- Hides the RAM's 1-cycle synchronous read latency behind a 2-entry output stage, giving 1 byte/cycle sustained throughput.
- Provides flush, level, almost-full and a sticky overflow flag.

---
 rtl/isp_byte_fifo_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/isp_byte_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// isp_byte_fifo_ctrl
//
// First-word-fall-through byte FIFO controller. It drives an external
// 2**AW x DW single-clock two-port SRAM (synchronous write, 1-cycle
// synchronous read) and turns it into a ready/valid stream buffer. The FIFO
// sits between the MSS byte source (APB/UART shim) and the ISP bitstream
// consumer.
//
// The RAM read latency is hidden behind a 2-entry output stage (out + skid).
// Up to two bytes are kept in flight ahead of the consumer, which gives one
// byte per cycle sustained throughput.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising CLK edge when valid && ready are both high.
//   WR_READY does not depend on WR_VALID, and RD_VALID does not depend on
//   RD_READY. Once RD_VALID is high, RD_VALID and RD_DATA stay stable until
//   RD_READY accepts the byte. RD_READY while !RD_VALID has no effect.
//   A WR_VALID while FULL is dropped and sets the sticky OVERFLOW flag.
//
// Ports:
//   CLK, ARST_N       clock (rising edge), asynchronous active-low reset
//   FLUSH             synchronous clear of all state, including OVERFLOW
//   WR_VALID/READY    producer handshake; WR_DATA is the byte offered
//   RD_VALID/READY    consumer handshake; RD_DATA is the head byte
//   COUNT             bytes held: RAM + output stage + in-flight read
//   FULL/EMPTY        COUNT == 2**AW+2 / COUNT == 0
//   ALMOST_FULL       COUNT >= AFULL_LVL
//   OVERFLOW          sticky: a write was attempted while FULL
//   RAM_*             SRAM write port (WADDR/WD/WEN) and read port
//                     (RADDR/REN/RD). RD is valid the cycle after REN.
// -----------------------------------------------------------------------------
module isp_byte_fifo_ctrl #(
   parameter int AW        = 6,
   parameter int DW        = 8,
   parameter int AFULL_LVL = 56
) (
   input  logic          CLK,
   input  logic          ARST_N,
   input  logic          FLUSH,
   input  logic          WR_VALID,
   output logic          WR_READY,
   input  logic [DW-1:0] WR_DATA,
   output logic          RD_VALID,
   input  logic          RD_READY,
   output logic [DW-1:0] RD_DATA,
   output logic [AW+1:0] COUNT,
   output logic          FULL,
   output logic          EMPTY,
   output logic          ALMOST_FULL,
   output logic          OVERFLOW,
   output logic [AW-1:0] RAM_WADDR,
   output logic [DW-1:0] RAM_WD,
   output logic          RAM_WEN,
   output logic [AW-1:0] RAM_RADDR,
   output logic          RAM_REN,
   input  logic [DW-1:0] RAM_RD
);

   // RAM depth plus the two output-stage entries.
   localparam int            CAP     = (2 ** AW) + 2;
   localparam logic [AW+1:0] CAP_V   = (AW + 2)'(CAP);
   localparam logic [AW+1:0] AFULL_V = (AW + 2)'(AFULL_LVL);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   ram_cnt;     // bytes written to RAM and not yet read out
   logic          out_v;
   logic [DW-1:0] out_q;
   logic          skid_v;
   logic [DW-1:0] skid_q;
   logic          inflight;    // RAM read issued last cycle, RAM_RD valid now
   logic [AW+1:0] count_q;
   logic          ovf_q;

   // ---------------------------------------------------------------------------
   // Next-state signals
   // ---------------------------------------------------------------------------
   logic          full;
   logic          wr_fire;
   logic          rd_fire;
   logic          rd_issue;
   logic [1:0]    stage_used;
   logic [1:0]    stage_after;
   logic [AW:0]   ram_cnt_nxt;
   logic          out_v_nxt;
   logic [DW-1:0] out_nxt;
   logic          skid_v_nxt;
   logic [DW-1:0] skid_nxt;
   logic [AW+1:0] count_nxt;

   assign full    = (count_q == CAP_V);
   assign wr_fire = WR_VALID && !full && !FLUSH;
   assign rd_fire = out_v && RD_READY;

   // Output-stage occupancy, counting the read already in flight, and what is
   // left once this cycle's consumer transfer is taken out.
   assign stage_used  = 2'(out_v) + 2'(skid_v) + 2'(inflight);
   assign stage_after = stage_used - 2'(rd_fire);

   // A new read is issued only if it is guaranteed a slot when it lands.
   // ram_cnt is the registered value, so a byte written this cycle is never
   // read in the same cycle. The read and write addresses are therefore never
   // equal while both enables are high: wptr == rptr only when the RAM is
   // empty (no read) or holds 2**AW bytes (stages full, FIFO FULL, no write).
   assign rd_issue = !FLUSH && (ram_cnt != '0) && (stage_after < 2'd2);

   always_comb begin
      ram_cnt_nxt = ram_cnt;
      unique case ({wr_fire, rd_issue})
         2'b10:   ram_cnt_nxt = ram_cnt + (AW + 1)'(1);
         2'b01:   ram_cnt_nxt = ram_cnt - (AW + 1)'(1);
         default: ram_cnt_nxt = ram_cnt;
      endcase
   end

   // Output stage. Byte order is out (oldest), then skid, then the in-flight
   // RAM read. When out is consumed, skid moves up and the landing byte goes
   // behind it. Otherwise the landing byte takes the first free slot.
   always_comb begin
      out_v_nxt  = out_v;
      out_nxt    = out_q;
      skid_v_nxt = skid_v;
      skid_nxt   = skid_q;
      if (rd_fire) begin
         if (skid_v) begin
            out_v_nxt  = 1'b1;
            out_nxt    = skid_q;
            skid_v_nxt = inflight;
            if (inflight) begin
               skid_nxt = RAM_RD;
            end
         end else begin
            out_v_nxt = inflight;
            if (inflight) begin
               out_nxt = RAM_RD;
            end
         end
      end else if (inflight) begin
         if (!out_v) begin
            out_v_nxt = 1'b1;
            out_nxt   = RAM_RD;
         end else begin
            skid_v_nxt = 1'b1;
            skid_nxt   = RAM_RD;
         end
      end
   end

   // COUNT is a registered copy of what the pieces will hold after this edge.
   assign count_nxt = (AW + 2)'(ram_cnt_nxt) + (AW + 2)'(out_v_nxt)
                    + (AW + 2)'(skid_v_nxt)  + (AW + 2)'(rd_issue);

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge ARST_N) begin
      if (!ARST_N) begin
         wptr     <= '0;
         rptr     <= '0;
         ram_cnt  <= '0;
         out_v    <= 1'b0;
         out_q    <= '0;
         skid_v   <= 1'b0;
         skid_q   <= '0;
         inflight <= 1'b0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else if (FLUSH) begin
         // Any in-flight RAM read is dropped by clearing inflight. The data
         // registers keep stale contents; they are hidden behind the cleared
         // valid bits.
         wptr     <= '0;
         rptr     <= '0;
         ram_cnt  <= '0;
         out_v    <= 1'b0;
         skid_v   <= 1'b0;
         inflight <= 1'b0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (wr_fire) begin
            wptr <= wptr + AW'(1);
         end
         if (rd_issue) begin
            rptr <= rptr + AW'(1);
         end
         ram_cnt  <= ram_cnt_nxt;
         out_v    <= out_v_nxt;
         out_q    <= out_nxt;
         skid_v   <= skid_v_nxt;
         skid_q   <= skid_nxt;
         inflight <= rd_issue;
         count_q  <= count_nxt;
         if (WR_VALID && full) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign WR_READY    = !full;
   assign RD_VALID    = out_v;
   assign RD_DATA     = out_q;
   assign COUNT       = count_q;
   assign FULL        = full;
   assign EMPTY       = (count_q == '0);
   assign ALMOST_FULL = (count_q >= AFULL_V);
   assign OVERFLOW    = ovf_q;

   assign RAM_WADDR = wptr;
   assign RAM_WD    = WR_DATA;
   assign RAM_WEN   = wr_fire;
   assign RAM_RADDR = rptr;
   assign RAM_REN   = rd_issue;

endmodule
